// File: rtl/sram_turn_arbiter.sv
// N-client turn arbiter for one asynchronous 8-bit SRAM: port 0 has fixed priority, ports 1..N-1 share round-robin.
// Optional macro SRAM_ARB_ANTISTARVE_EN lets a waiting round-robin port win over port 0 after STARVE_LIMIT port-0 grants.
module sram_turn_arbiter #(
  parameter int unsigned NUM_PORTS     = 3,
  parameter int unsigned ADDR_W        = 19,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*8-1:0]      wdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [7:0]                  rdata,
  output logic [2:0]                  grant_id,
  output logic                        busy,
  output logic [ADDR_W-1:0]           sram_a,
  output logic                        sram_we_n,
  output logic [7:0]                  sram_d_out,
  output logic                        sram_d_oe,
  input  logic [7:0]                  sram_d_in
);

  localparam int unsigned CNT_W       = 4;
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(ACCESS_CYCLES - 2);

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || ACCESS_CYCLES < 2 || ACCESS_CYCLES > 15 ||
      STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_param
    $error("sram_turn_arbiter: parameter out of legal range");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [2:0]            r_ptr, w_ptr_nxt;
  logic                  r_we, w_we_nxt;
  logic [NUM_PORTS-1:0]  r_ack, w_ack_nxt;
  logic [7:0]            r_rdata, w_rdata_nxt;
  logic [2:0]            r_grant, w_grant_nxt;
  logic                  r_busy, w_busy_nxt;
  logic [ADDR_W-1:0]     r_a, w_a_nxt;
  logic                  r_we_n, w_we_n_nxt;
  logic [7:0]            r_d_out, w_d_out_nxt;
  logic                  r_d_oe, w_d_oe_nxt;

  logic                  w_rr_found, w_lo_found, w_starve_hit, w_pick_rr;
  logic [2:0]            w_rr_win, w_lo_win, w_win;
  logic [ADDR_W-1:0]     w_sel_addr;
  logic                  w_sel_we;
  logic [7:0]            w_sel_wdata;

  // Round-robin search over 1..N-1: lowest requester at/after the pointer, else lowest requester overall.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_win   = 3'd1;
    w_lo_found = 1'b0;
    w_lo_win   = 3'd1;
    for (int p = int'(NUM_PORTS) - 1; p >= 1; p--) begin
      if (req[p]) begin
        w_lo_found = 1'b1;
        w_lo_win   = 3'(p);
        if (3'(p) >= r_ptr) begin
          w_rr_found = 1'b1;
          w_rr_win   = 3'(p);
        end
      end
    end
    if (!w_rr_found) begin
      w_rr_found = w_lo_found;
      w_rr_win   = w_lo_win;
    end
  end

  assign w_pick_rr = w_rr_found && (!req[0] || w_starve_hit);
  assign w_win     = w_pick_rr ? w_rr_win : 3'd0;

  always_comb begin
    w_sel_addr  = addr[ADDR_W-1:0];
    w_sel_we    = we[0];
    w_sel_wdata = wdata[7:0];
    for (int p = 1; p < int'(NUM_PORTS); p++) begin
      if (w_win == 3'(p)) begin
        w_sel_addr  = addr[p*ADDR_W +: ADDR_W];
        w_sel_we    = we[p];
        w_sel_wdata = wdata[p*8 +: 8];
      end
    end
  end

`ifdef SRAM_ARB_ANTISTARVE_EN
  logic [3:0] r_starve, w_starve_nxt;

  assign w_starve_hit = (r_starve >= 4'(STARVE_LIMIT));

  // Counts port-0 grants that bypassed a waiting round-robin port.
  always_comb begin
    w_starve_nxt = r_starve;
    if (r_state == S_IDLE && |req) begin
      if (w_pick_rr)
        w_starve_nxt = 4'd0;
      else if (w_rr_found && r_starve != 4'hF)
        w_starve_nxt = r_starve + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_starve <= 4'd0;
    else     r_starve <= w_starve_nxt;
  end
`else
  assign w_starve_hit = 1'b0;
`endif

  // Access sequencer; every pin-facing value is computed here and registered below.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_we_nxt    = r_we;
    w_ack_nxt   = '0;
    w_rdata_nxt = r_rdata;
    w_grant_nxt = r_grant;
    w_a_nxt     = r_a;
    w_we_n_nxt  = 1'b1;
    w_d_out_nxt = r_d_out;
    w_d_oe_nxt  = r_d_oe;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt = S_SETUP;
          w_grant_nxt = w_win;
          w_a_nxt     = w_sel_addr;
          w_we_nxt    = w_sel_we;
          w_d_out_nxt = w_sel_wdata;
          w_d_oe_nxt  = w_sel_we;
          if (w_pick_rr)
            w_ptr_nxt = (w_win == 3'(NUM_PORTS - 1)) ? 3'd1 : w_win + 3'd1;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_STROBE;
        w_cnt_nxt   = '0;
        w_we_n_nxt  = !r_we;
      end
      S_STROBE: begin
        if (r_cnt == STROBE_LAST) begin
          w_state_nxt = S_HOLD;
          for (int p = 0; p < int'(NUM_PORTS); p++)
            w_ack_nxt[p] = (r_grant == 3'(p));
          if (!r_we)
            w_rdata_nxt = sram_d_in;
        end else begin
          w_cnt_nxt  = r_cnt + CNT_W'(1);
          w_we_n_nxt = !r_we;
        end
      end
      S_HOLD: begin
        w_state_nxt = S_IDLE;
        w_d_oe_nxt  = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= 3'd1;
      r_we    <= 1'b0;
      r_ack   <= '0;
      r_rdata <= 8'h00;
      r_grant <= 3'd0;
      r_busy  <= 1'b0;
      r_a     <= '0;
      r_we_n  <= 1'b1;
      r_d_out <= 8'h00;
      r_d_oe  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_we    <= w_we_nxt;
      r_ack   <= w_ack_nxt;
      r_rdata <= w_rdata_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= w_busy_nxt;
      r_a     <= w_a_nxt;
      r_we_n  <= w_we_n_nxt;
      r_d_out <= w_d_out_nxt;
      r_d_oe  <= w_d_oe_nxt;
    end
  end

  assign ack        = r_ack;
  assign rdata      = r_rdata;
  assign grant_id   = r_grant;
  assign busy       = r_busy;
  assign sram_a     = r_a;
  assign sram_we_n  = r_we_n;
  assign sram_d_out = r_d_out;
  assign sram_d_oe  = r_d_oe;

endmodule

// File: tb/tb_sram_turn_arbiter.sv
// Directed bench for sram_turn_arbiter with an SRAM model and an ack scoreboard.
module tb_sram_turn_arbiter;

  localparam int unsigned NP = 3;
  localparam int unsigned AW = 19;
  localparam int unsigned AC = 4;
  localparam int unsigned SL = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req, we, ack;
  logic [NP*AW-1:0] addr;
  logic [NP*8-1:0]  wdata;
  logic [7:0]       rdata, sram_d_out, sram_d_in;
  logic [2:0]       grant_id;
  logic             busy, sram_we_n, sram_d_oe;
  logic [AW-1:0]    sram_a;

  sram_turn_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .grant_id(grant_id), .busy(busy),
    .sram_a(sram_a), .sram_we_n(sram_we_n), .sram_d_out(sram_d_out),
    .sram_d_oe(sram_d_oe), .sram_d_in(sram_d_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous SRAM model with a preload port for the bench.
  logic [7:0]    mem [0:(1<<AW)-1];
  logic          pl_en;
  logic [AW-1:0] pl_a;
  logic [7:0]    pl_d;
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (!sram_we_n && sram_d_oe) mem[sram_a] <= sram_d_out;
  end
  assign sram_d_in = mem[sram_a];

  typedef struct packed {
    logic [2:0] port;
    logic       is_rd;
    logic [7:0] rdata;
  } sb_t;
  sb_t sb[$];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    sb_t        e;
    logic [2:0] oh;
    if (!busy && !rst) chk("we_n_idle", 32'(sram_we_n), 32'h1);
    if (|ack) begin
      if (sb.size() == 0) begin
        chk("ack_unexpected", 32'(ack), 32'h0);
      end else begin
        e  = sb.pop_front();
        oh = 3'b001 << e.port;
        chk("sb_ack_port", 32'(ack), 32'(oh));
        chk("sb_grant_id", 32'(grant_id), 32'(e.port));
        if (e.is_rd) chk("sb_rdata", 32'(rdata), 32'(e.rdata));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ack(output int t);
    bit got;
    got = 1'b0;
    t   = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (|ack) begin
        got = 1'b1;
        t   = cyc;
      end
    end
    chk("ack_timeout", 32'(got), 32'h1);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_en = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [7:0] d);
    we[p]              = w;
    addr[p*AW +: AW]   = a;
    wdata[p*8 +: 8]    = d;
  endtask

  task automatic push(input int p, input logic rd, input logic [7:0] d);
    sb_t e;
    e.port  = 3'(p);
    e.is_rd = rd;
    e.rdata = d;
    sb.push_back(e);
  endtask

  initial begin
    int t1, t2, lowcnt;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; pl_en = 1'b0; pl_a = '0; pl_d = '0;
    preload(19'h12345, 8'hA5);
    preload(19'h00100, 8'h11);
    preload(19'h00200, 8'h22);
    preload(19'h00300, 8'h33);
    preload(19'h00400, 8'h44);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sram_a", 32'(sram_a), 32'h0);
    chk("rst_we_n", 32'(sram_we_n), 32'h1);
    chk("rst_d_oe", 32'(sram_d_oe), 32'h0);
    chk("rst_d_out", 32'(sram_d_out), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Single read from port 1.
    @(posedge clk); #1;
    set_port(1, 1'b0, 19'h12345, 8'h00); req[1] = 1'b1; push(1, 1'b1, 8'hA5);
    for (int k = 1; k <= int'(AC) + 1; k++) begin
      step();
      if (k == 1) chk("rd_sram_a", 32'(sram_a), 32'h12345);
      chk("rd_we_n", 32'(sram_we_n), 32'h1);
      chk("rd_busy", 32'(busy), 32'h1);
      chk("rd_ack_time", 32'(ack), (k == int'(AC) + 1) ? 32'h2 : 32'h0);
      if (k == int'(AC) + 1) begin
        chk("rd_rdata", 32'(rdata), 32'hA5);
        req[1] = 1'b0;
      end
    end

    // Write from port 2: strobe length and pad enable window.
    @(posedge clk); #1;
    set_port(2, 1'b1, 19'h00010, 8'h3C); req[2] = 1'b1; push(2, 1'b0, 8'h00);
    lowcnt = 0;
    for (int k = 1; k <= int'(AC) + 1; k++) begin
      step();
      chk("wr_d_oe", 32'(sram_d_oe), 32'h1);
      if (k == 1) chk("wr_d_out", 32'(sram_d_out), 32'h3C);
      if (!sram_we_n) lowcnt++;
      chk("wr_we_n", 32'(sram_we_n), (k >= 2 && k <= int'(AC)) ? 32'h0 : 32'h1);
      if (k == int'(AC) + 1) begin
        chk("wr_ack_time", 32'(ack), 32'h4);
        req[2] = 1'b0;
      end
    end
    step();
    chk("wr_d_oe_off", 32'(sram_d_oe), 32'h0);
    chk("wr_busy_off", 32'(busy), 32'h0);
    chk("wr_low_cycles", 32'(lowcnt), 32'(AC - 1));
    chk("wr_mem", 32'(mem[19'h00010]), 32'h3C);
    chk("wr_rdata_kept", 32'(rdata), 32'hA5);

    // Fixed priority, then round-robin among ports 1 and 2.
    set_port(0, 1'b0, 19'h00100, 8'h00);
    set_port(1, 1'b0, 19'h00200, 8'h00);
    set_port(2, 1'b0, 19'h00300, 8'h00);
    req = 3'b111;
    push(0, 1'b1, 8'h11); push(0, 1'b1, 8'h11); push(0, 1'b1, 8'h11);
    push(1, 1'b1, 8'h22); push(2, 1'b1, 8'h33); push(1, 1'b1, 8'h22); push(2, 1'b1, 8'h33);
    for (int i = 0; i < 3; i++) wait_ack(t1);
    req[0] = 1'b0;
    for (int i = 0; i < 4; i++) wait_ack(t1);
    req = '0;
    step(); step();

    // Back-to-back reads from port 1 with the SRAM contents changing in between.
    set_port(1, 1'b0, 19'h00400, 8'h00); req[1] = 1'b1;
    push(1, 1'b1, 8'h44); push(1, 1'b1, 8'h55);
    wait_ack(t1);
    preload(19'h00400, 8'h55);
    wait_ack(t2);
    req[1] = 1'b0;
    chk("b2b_spacing", 32'(t2 - t1), 32'(AC + 2));
    step();

    // Reset during a write strobe.
    set_port(2, 1'b1, 19'h00500, 8'h77); req[2] = 1'b1;
    step();
    chk("rw_setup_oe", 32'(sram_d_oe), 32'h1);
    step();
    chk("rw_strobe_we_n", 32'(sram_we_n), 32'h0);
    rst = 1'b1;
    step();
    chk("rw_we_n", 32'(sram_we_n), 32'h1);
    chk("rw_d_oe", 32'(sram_d_oe), 32'h0);
    chk("rw_busy", 32'(busy), 32'h0);
    chk("rw_ack", 32'(ack), 32'h0);
    req[2] = 1'b0;
    rst    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rw_no_ack", 32'(ack), 32'h0);
    end

    // Port 0 against a constantly waiting port 1.
    set_port(0, 1'b0, 19'h00100, 8'h00);
    set_port(1, 1'b0, 19'h00200, 8'h00);
    req = 3'b011;
    for (int i = 0; i < 10; i++) begin
`ifdef SRAM_ARB_ANTISTARVE_EN
      if (i % (int'(SL) + 1) == int'(SL)) push(1, 1'b1, 8'h22);
      else                                push(0, 1'b1, 8'h11);
`else
      push(0, 1'b1, 8'h11);
`endif
    end
    for (int i = 0; i < 10; i++) wait_ack(t1);
    req = '0;
    step(); step(); step();
    chk("sb_drain", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_turn_arbiter.md
Name: sram_turn_arbiter

Overview:
- Parametrised successor to the two-client video/CPU SRAM turn multiplexer.
- Arbitrates N clients onto one asynchronous 8-bit external SRAM: port 0 is the real-time video port with fixed priority; ports 1..N-1 (CPU, disk DMA, etc.) share round-robin.
- Sits between the ASIC/CPU/disk address generators and the SRAM pins.
- Replaces combinational "whichturn" muxing with a registered access FSM with programmable strobe length.

Parameters:
- NUM_PORTS, 3, number of clients; legal range 2..8.
- ADDR_W, 19, SRAM address width.
- ACCESS_CYCLES, 2, clock cycles from address valid to end of strobe; legal range 2..15.
- STARVE_LIMIT, 4, consecutive port-0 grants tolerated while a round-robin port waits. Used only with the optional feature.

Ports:
- clk  in  1  single clock; every register is clocked on its rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_PORTS  per-port level request; held until ack.
- we  in  NUM_PORTS  per-port write enable; 1 means write. Sampled with req.
- addr  in  NUM_PORTS*ADDR_W  packed addresses; port i is bits [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_PORTS*8  packed write data; port i is bits [i*8 +: 8].
- ack  out  NUM_PORTS  one-cycle completion pulse, one-hot.
- rdata  out  8  read data; valid in the ack cycle, held until the next read completes.
- grant_id  out  3  index of the port currently being serviced.
- busy  out  1  high in any state other than IDLE.
- sram_a  out  ADDR_W  SRAM address.
- sram_we_n  out  1  SRAM write strobe, active-low.
- sram_d_out  out  8  data to the SRAM.
- sram_d_oe  out  1  pad output enable for sram_d_out.
- sram_d_in  in  8  data from the SRAM.

Behaviour:
- Reset values: ack=0, rdata=0x00, grant_id=0, busy=0, sram_a=0, sram_we_n=1, sram_d_oe=0, sram_d_out=0x00, state=IDLE, round-robin pointer=port 1.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE:
  - If any req is high, select a winner.
  - Port 0 wins whenever req[0]=1.
  - Otherwise the first requesting port at or after the pointer wins, searching 1..N-1 with wrap.
  - On grant, register sram_a, the write flag, sram_d_out and grant_id, then go to SETUP.
  - The pointer moves to winner+1 (wrapping to port 1) only when a round-robin port wins.
- SETUP (1 cycle):
  - Address stable; sram_we_n=1.
  - sram_d_oe=1 if write.
- STROBE (ACCESS_CYCLES-1 cycles, counter):
  - sram_we_n=0 if write.
  - On a read, capture sram_d_in into rdata on the last STROBE cycle.
- HOLD (1 cycle):
  - sram_we_n=1; address and data still held (hold time).
  - ack[grant_id]=1.
  - sram_d_oe drops on exit.
- Latency: req sampled in IDLE at cycle T gives ack at T+ACCESS_CYCLES+1. One access per ACCESS_CYCLES+2 cycles.
- Clients keep addr/we/wdata stable from req until ack. A req still high in the cycle after ack is treated as a new access.
- Requests that rise while busy=1 are only evaluated in the next IDLE cycle. There is no preemption: an active access always completes.
- A deasserted req while the port is granted has no effect; the access still completes and acks.
- rdata is unchanged by writes.
- sram_we_n is never low in SETUP, HOLD or IDLE, so there are no glitches on address change.
- rst asserted mid-access: the next edge forces reset values (sram_we_n=1, sram_d_oe=0), no ack is issued, and the aborted write may be partial.
- A port index ≥ NUM_PORTS is never granted.

Optional Feature:
- Macro: SRAM_ARB_ANTISTARVE_EN.
- Defined:
  - A 4-bit counter increments on each port-0 grant made while any req[1..N-1] is high.
  - When the counter reaches STARVE_LIMIT, the next IDLE arbitration gives priority to the round-robin winner over port 0, and the counter clears.
  - The counter also clears on any round-robin grant and on rst.
- Undefined: port 0 has absolute priority, there is no counter, and round-robin ports can starve indefinitely.

Test Plan:
- Reset then a single read: port 1 reads addr 0x12345 and the SRAM model returns 0xA5 -> sram_a=0x12345 from T+1, sram_we_n stays 1, ack[1] pulses at T+3, rdata=0xA5.
- Write timing: port 2 writes 0x3C to 0x00010 with ACCESS_CYCLES=4 -> sram_we_n low for exactly 3 cycles, sram_d_oe high SETUP..HOLD, ack[2] at T+5, memory model holds 0x3C.
- Priority and round-robin: req=3'b111 held continuously -> grant order 0,0,0… Then with req[0] dropped and req=3'b110 -> order 1,2,1,2.
- Back-to-back: port 1 keeps req high through ack -> the second access starts in the cycle after HOLD, spacing exactly ACCESS_CYCLES+2 cycles, rdata updated each read.
- Reset mid-write: rst asserted during STROBE -> next cycle sram_we_n=1, sram_d_oe=0, busy=0, no ack pulse.
- With SRAM_ARB_ANTISTARVE_EN, STARVE_LIMIT=4, req=3'b011 constant -> grants 0,0,0,0,1,0,0,0,0,1. Without the macro -> port 0 only.
